// File: rtl/ysyx_25010008_xbar_if.sv
// Bus bundles for the crossbar: the upstream single-beat AXI4-lite-style link and
// the downstream AXI4 master link towards the SoC.
interface ysyx_25010008_xbar_if;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    modport master (
        output araddr, arsize, arvalid, input arready,
        input rdata, rresp, rvalid, output rready,
        output awaddr, awsize, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready
    );
    modport slave (
        input araddr, arsize, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input awaddr, awsize, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready
    );
endinterface

interface ysyx_25010008_xbar_axi_if;
    logic        arvalid, arready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready, rlast;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        awvalid, awready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wready, wlast;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [3:0]  bid;
    logic [1:0]  bresp;

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst, input arready,
        input rvalid, rid, rdata, rresp, rlast, output rready,
        output awvalid, awid, awaddr, awlen, awsize, awburst, input awready,
        output wvalid, wdata, wstrb, wlast, input wready,
        input bvalid, bid, bresp, output bready
    );
    modport slave (
        input arvalid, arid, araddr, arlen, arsize, arburst, output arready,
        output rvalid, rid, rdata, rresp, rlast, input rready,
        input awvalid, awid, awaddr, awlen, awsize, awburst, output awready,
        input wvalid, wdata, wstrb, wlast, output wready,
        output bvalid, bid, bresp, input bready
    );
endinterface

// File: rtl/ysyx_25010008_xbar.sv
// Routes one upstream transaction at a time to the SoC AXI4 port or the built-in CLINT mtime.
// Define XBAR_MTIME_WRITE_EN to make mtime writable; otherwise CLINT writes return SLVERR.
module ysyx_25010008_xbar #(
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000,
    parameter int unsigned MTIME_STEP = 1
) (
    input  logic                            clock,
    input  logic                            reset,
    ysyx_25010008_xbar_if.slave             up,
    ysyx_25010008_xbar_axi_if.master        io_master
);
    typedef enum logic [2:0] {IDLE, RD_DEV, RD_RESP, WR_DEV_AW, WR_DEV_W, WR_RESP} state_e;

    localparam logic [31:0] MTIME_LO = 32'h0000_BFF8;
    localparam logic [31:0] MTIME_HI = 32'h0000_BFFC;
    localparam logic [1:0]  OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    state_e      state_q, state_d;
    logic [63:0] mtime_q, mtime_d;
    logic [31:0] addr_q, addr_d, rdata_q, rdata_d, wdata_q, wdata_d;
    logic [2:0]  size_q, size_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  resp_q, resp_d;
    logic        arvalid_q, arvalid_d, awvalid_q, awvalid_d, wvalid_q, wvalid_d;

    logic        rd_acc, wr_acc, rd_hit, wr_hit;
    logic [31:0] rd_off, wr_off;
    logic        unused_ok;

    // Reads win when both request types arrive together.
    assign rd_acc = (state_q == IDLE) && up.arvalid;
    assign wr_acc = (state_q == IDLE) && !up.arvalid && up.awvalid && up.wvalid;
    assign rd_hit = (up.araddr & CLINT_MASK) == CLINT_BASE;
    assign wr_hit = (up.awaddr & CLINT_MASK) == CLINT_BASE;
    assign rd_off = up.araddr & ~CLINT_MASK;
    assign wr_off = up.awaddr & ~CLINT_MASK;

    assign up.arready = (state_q == IDLE);
    assign up.awready = (state_q == IDLE) && !up.arvalid;
    assign up.wready  = (state_q == IDLE) && !up.arvalid;
    assign up.rvalid  = (state_q == RD_RESP);
    assign up.rdata   = rdata_q;
    assign up.rresp   = resp_q;
    assign up.bvalid  = (state_q == WR_RESP);
    assign up.bresp   = resp_q;

    assign io_master.arvalid = arvalid_q;
    assign io_master.arid    = 4'd0;
    assign io_master.araddr  = addr_q;
    assign io_master.arlen   = 8'd0;
    assign io_master.arsize  = size_q;
    assign io_master.arburst = 2'b01;
    // R may be taken in the same cycle the AR handshake completes.
    assign io_master.rready  = (state_q == RD_DEV) && (!arvalid_q || io_master.arready);
    assign io_master.awvalid = awvalid_q;
    assign io_master.awid    = 4'd0;
    assign io_master.awaddr  = addr_q;
    assign io_master.awlen   = 8'd0;
    assign io_master.awsize  = size_q;
    assign io_master.awburst = 2'b01;
    assign io_master.wvalid  = wvalid_q;
    assign io_master.wdata   = wdata_q;
    assign io_master.wstrb   = wstrb_q;
    assign io_master.wlast   = wvalid_q;
    assign io_master.bready  = (state_q == WR_DEV_W) && !wvalid_q;

    assign unused_ok = ^{io_master.rid, io_master.rlast, io_master.bid};

    always_comb begin
        state_d   = state_q;
        mtime_d   = mtime_q + 64'(MTIME_STEP);
        addr_d    = addr_q;
        size_d    = size_q;
        rdata_d   = rdata_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        resp_d    = resp_q;
        arvalid_d = arvalid_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        case (state_q)
            IDLE: begin
                if (rd_acc) begin
                    if (rd_hit) begin
                        state_d = RD_RESP;
                        resp_d  = OKAY;
                        if (rd_off == MTIME_LO)      rdata_d = mtime_q[31:0];
                        else if (rd_off == MTIME_HI) rdata_d = mtime_q[63:32];
                        else begin
                            rdata_d = '0;
                            resp_d  = DECERR;
                        end
                    end else begin
                        state_d   = RD_DEV;
                        addr_d    = up.araddr;
                        size_d    = up.arsize;
                        arvalid_d = 1'b1;
                    end
                end else if (wr_acc) begin
                    if (wr_hit) begin
                        state_d = WR_RESP;
`ifdef XBAR_MTIME_WRITE_EN
                        resp_d  = OKAY;
                        // A write replaces this cycle's increment for the whole counter.
                        if (wr_off == MTIME_LO) begin
                            mtime_d = mtime_q;
                            for (int b = 0; b < 4; b++)
                                if (up.wstrb[b]) mtime_d[8*b +: 8] = up.wdata[8*b +: 8];
                        end else if (wr_off == MTIME_HI) begin
                            mtime_d = mtime_q;
                            for (int b = 0; b < 4; b++)
                                if (up.wstrb[b]) mtime_d[32+8*b +: 8] = up.wdata[8*b +: 8];
                        end else begin
                            resp_d = DECERR;
                        end
`else
                        resp_d  = SLVERR;
`endif
                    end else begin
                        state_d   = WR_DEV_AW;
                        addr_d    = up.awaddr;
                        size_d    = up.awsize;
                        wdata_d   = up.wdata;
                        wstrb_d   = up.wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end
                end
            end
            RD_DEV: begin
                if (arvalid_q && io_master.arready) arvalid_d = 1'b0;
                if (io_master.rvalid && io_master.rready) begin
                    rdata_d = io_master.rdata;
                    resp_d  = io_master.rresp;
                    state_d = RD_RESP;
                end
            end
            RD_RESP: if (up.rready) state_d = IDLE;
            WR_DEV_AW: begin
                if (wvalid_q && io_master.wready) wvalid_d = 1'b0;
                if (io_master.awready) begin
                    awvalid_d = 1'b0;
                    state_d   = WR_DEV_W;
                end
            end
            WR_DEV_W: begin
                if (wvalid_q && io_master.wready) wvalid_d = 1'b0;
                if (io_master.bvalid && io_master.bready) begin
                    resp_d  = io_master.bresp;
                    state_d = WR_RESP;
                end
            end
            WR_RESP: if (up.bready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            mtime_q   <= '0;
            addr_q    <= '0;
            size_q    <= '0;
            rdata_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            resp_q    <= '0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mtime_q   <= mtime_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            rdata_q   <= rdata_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            resp_q    <= resp_d;
            arvalid_q <= arvalid_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
        end
    end
endmodule
